cdp_rdma_reg_group_ctrl: RTL and testbench

Ping-pong register-group scheduler for the CDP RDMA register block. It routes dual-group register writes to group 0 or group 1 according to the software `producer` pointer. It tracks each group's op_enable and launches the datapath on the group selected by the hardware `consumer` pointer. On layer completion it clears that group and toggles `consumer`. It drives the read-only `consumer`, `status_0` and `status_1` fields of the single-register block.

---
 rtl/cdp_rdma_reg_pkg.sv | 32 +++
 rtl/cdp_rdma_group_slot.sv | 44 ++++
 rtl/cdp_rdma_reg_group_ctrl.sv | 106 ++++++++++
 tb/tb_cdp_rdma_reg_group_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cdp_rdma_reg_pkg.sv
// Shared types and constants for the CDP RDMA ping-pong register group scheduler.
package cdp_rdma_reg_pkg;

  localparam int unsigned OFFS_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STAT_W = 2;

  localparam logic [OFFS_W-1:0] OP_EN_OFFSET = 12'h008;
  localparam logic [OFFS_W-1:0] DUAL_BASE    = 12'h008;
  localparam logic [OFFS_W-1:0] DUAL_TOP     = 12'h0fc;

  typedef enum logic [STAT_W-1:0] {
    GRP_IDLE    = 2'd0,
    GRP_RUNNING = 2'd1,
    GRP_PENDING = 2'd2
  } grp_status_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_LOAD = 2'd1,
    FSM_BUSY = 2'd2,
    FSM_DONE = 2'd3
  } ctrl_state_e;

  // Group status from its op_enable and whether the controller is running it.
  function automatic grp_status_e encode_status(input logic op_en, input logic running);
    if (!op_en)  return GRP_IDLE;
    if (running) return GRP_RUNNING;
    return GRP_PENDING;
  endfunction

endpackage

// File: rtl/cdp_rdma_group_slot.sv
// One register group: op_enable flop, lock check, write enable and status.
module cdp_rdma_group_slot
  import cdp_rdma_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              dual_hit,
  input  logic              op_en_wr,
  input  logic              clr,
  input  logic              run_nxt,
  output logic              op_en,
  output logic              reg_wren_c,
  output logic              locked_hit_c,
  output logic [STAT_W-1:0] status
);

  logic        op_en_q, op_en_d;
  grp_status_e status_q, status_d;

  // A set can only land on an unlocked group, so it never collides with a clear.
  always_comb begin
    reg_wren_c   = sel & dual_hit & ~op_en_q;
    locked_hit_c = sel & dual_hit & op_en_q;
    op_en_d      = op_en_q;
    if (reg_wren_c && op_en_wr) op_en_d = 1'b1;
    if (clr)                    op_en_d = 1'b0;
    status_d = encode_status(op_en_d, run_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_en_q  <= 1'b0;
      status_q <= GRP_IDLE;
    end else begin
      op_en_q  <= op_en_d;
      status_q <= status_d;
    end
  end

  assign op_en  = op_en_q;
  assign status = status_q;

endmodule

// File: rtl/cdp_rdma_reg_group_ctrl.sv
// Ping-pong group scheduler: routes dual writes by producer, launches by consumer.
module cdp_rdma_reg_group_ctrl
  import cdp_rdma_reg_pkg::*;
(
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic [OFFS_W-1:0] reg_offset,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic              reg_wr_en,
  input  logic              producer,
  input  logic              dp2reg_done,
  output logic              consumer,
  output logic [STAT_W-1:0] status_0,
  output logic [STAT_W-1:0] status_1,
  output logic              d0_reg_wren,
  output logic              d1_reg_wren,
  output logic              reg2dp_op_load,
  output logic              reg2dp_op_en,
  output logic              wr_locked_err
);

  ctrl_state_e state_q, state_d;
  logic        consumer_q, consumer_d;
  logic        op_load_q, op_load_d;
  logic        op_en_out_q, op_en_out_d;
  logic        err_q, err_d;

  logic dual_hit, op_en_wr, run_nxt;
  logic op_en0, op_en1, op_en_cons;
  logic lock0_c, lock1_c;
  logic unused_wr_data;

  assign dual_hit       = reg_wr_en && (reg_offset >= DUAL_BASE) && (reg_offset <= DUAL_TOP);
  assign op_en_wr       = (reg_offset == OP_EN_OFFSET) && reg_wr_data[0];
  assign unused_wr_data = ^reg_wr_data[DATA_W-1:1];
  assign op_en_cons     = consumer_q ? op_en1 : op_en0;

  always_comb begin
    state_d    = state_q;
    consumer_d = consumer_q;
    case (state_q)
      FSM_IDLE: if (op_en_cons) state_d = FSM_LOAD;
      FSM_LOAD: state_d = FSM_BUSY;
      FSM_BUSY: if (dp2reg_done) state_d = FSM_DONE;
      FSM_DONE: begin
        state_d    = FSM_IDLE;
        consumer_d = ~consumer_q;
      end
      default:  state_d = FSM_IDLE;
    endcase
    run_nxt     = (state_d == FSM_LOAD) || (state_d == FSM_BUSY);
    op_load_d   = (state_d == FSM_LOAD);
    op_en_out_d = run_nxt;
    err_d       = lock0_c | lock1_c;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= FSM_IDLE;
      consumer_q  <= 1'b0;
      op_load_q   <= 1'b0;
      op_en_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      consumer_q  <= consumer_d;
      op_load_q   <= op_load_d;
      op_en_out_q <= op_en_out_d;
      err_q       <= err_d;
    end
  end

  cdp_rdma_group_slot u_slot0 (
    .clk          (nvdla_core_clk),
    .rst_n        (nvdla_core_rstn),
    .sel          (~producer),
    .dual_hit     (dual_hit),
    .op_en_wr     (op_en_wr),
    .clr          ((state_q == FSM_DONE) && !consumer_q),
    .run_nxt      (run_nxt && !consumer_d),
    .op_en        (op_en0),
    .reg_wren_c   (d0_reg_wren),
    .locked_hit_c (lock0_c),
    .status       (status_0)
  );

  cdp_rdma_group_slot u_slot1 (
    .clk          (nvdla_core_clk),
    .rst_n        (nvdla_core_rstn),
    .sel          (producer),
    .dual_hit     (dual_hit),
    .op_en_wr     (op_en_wr),
    .clr          ((state_q == FSM_DONE) && consumer_q),
    .run_nxt      (run_nxt && consumer_d),
    .op_en        (op_en1),
    .reg_wren_c   (d1_reg_wren),
    .locked_hit_c (lock1_c),
    .status       (status_1)
  );

  assign consumer       = consumer_q;
  assign reg2dp_op_load = op_load_q;
  assign reg2dp_op_en   = op_en_out_q;
  assign wr_locked_err  = err_q;

endmodule

// File: tb/tb_cdp_rdma_reg_group_ctrl.sv
// Bench for cdp_rdma_reg_group_ctrl: behavioural group model plus pinned directed checks.
module tb_cdp_rdma_reg_group_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] t_off = '0;
  logic [31:0] t_data = '0;
  logic        t_we = 1'b0;
  logic        t_p = 1'b0;
  logic        t_done = 1'b0;

  logic        consumer, d0_reg_wren, d1_reg_wren, reg2dp_op_load, reg2dp_op_en, wr_locked_err;
  logic [1:0]  status_0, status_1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdp_rdma_reg_group_ctrl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .reg_offset      (t_off),
    .reg_wr_data     (t_data),
    .reg_wr_en       (t_we),
    .producer        (t_p),
    .dp2reg_done     (t_done),
    .consumer        (consumer),
    .status_0        (status_0),
    .status_1        (status_1),
    .d0_reg_wren     (d0_reg_wren),
    .d1_reg_wren     (d1_reg_wren),
    .reg2dp_op_load  (reg2dp_op_load),
    .reg2dp_op_en    (reg2dp_op_en),
    .wr_locked_err   (wr_locked_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: which groups hold work, which one the hardware serves, and where the layer is.
  bit m_op_en [2];
  bit m_cons, m_busy, m_load, m_clear, m_err;

  always @(posedge clk or negedge rstn) begin
    bit hit, set_g, idle, n_load, n_clear;
    if (!rstn) begin
      m_op_en[0] = 0; m_op_en[1] = 0;
      m_cons = 0; m_busy = 0; m_load = 0; m_clear = 0; m_err = 0;
    end else begin
      hit     = t_we && (t_off >= 12'h008) && (t_off <= 12'h0fc);
      set_g   = hit && !m_op_en[t_p] && (t_off == 12'h008) && t_data[0];
      idle    = !m_busy && !m_clear;
      n_load  = idle && m_op_en[m_cons];
      n_clear = m_busy && !m_load && t_done;
      m_err   = hit && m_op_en[t_p];
      if (set_g) m_op_en[t_p] = 1;
      if (m_clear) begin
        m_op_en[m_cons] = 0;
        m_cons = !m_cons;
      end
      m_busy  = n_load || (m_busy && !n_clear);
      m_load  = n_load;
      m_clear = n_clear;
    end
  end

  function automatic logic [1:0] exp_stat(input int g);
    if (!m_op_en[g]) return 2'd0;
    if (m_busy && (int'(m_cons) == g)) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic exp_wren(input int g);
    return t_we && (t_off >= 12'h008) && (t_off <= 12'h0fc) && (int'(t_p) == g) && !m_op_en[g];
  endfunction

  // Every-cycle comparison against the model, sampled mid-low-phase.
  always @(negedge clk) begin
    #1;
    chk("consumer", 32'(consumer), 32'(m_cons));
    chk("status_0", 32'(status_0), 32'(exp_stat(0)));
    chk("status_1", 32'(status_1), 32'(exp_stat(1)));
    chk("op_load", 32'(reg2dp_op_load), 32'(m_load));
    chk("op_en", 32'(reg2dp_op_en), 32'(m_busy));
    chk("locked_err", 32'(wr_locked_err), 32'(m_err));
    chk("d0_wren", 32'(d0_reg_wren), 32'(exp_wren(0)));
    chk("d1_wren", 32'(d1_reg_wren), 32'(exp_wren(1)));
  end

  task automatic drive(input logic [11:0] off, input logic [31:0] d, input logic we,
                       input logic p, input logic dn);
    @(posedge clk);
    #1;
    t_off = off; t_data = d; t_we = we; t_p = p; t_done = dn;
  endtask

  task automatic idle();
    drive(12'h000, 32'h0, 1'b0, t_p, 1'b0);
  endtask

  task automatic pin();
    @(negedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    pin();
    chk("rst_consumer", 32'(consumer), 32'd0);
    chk("rst_status_0", 32'(status_0), 32'd0);
    chk("rst_op_load", 32'(reg2dp_op_load), 32'd0);

    drive(12'h010, 32'h1234, 1'b1, 1'b0, 1'b0);
    pin();
    chk("pin_d0_wren", 32'(d0_reg_wren), 32'd1);
    chk("pin_d1_wren", 32'(d1_reg_wren), 32'd0);
    chk("pin_status_0_idle", 32'(status_0), 32'd0);

    drive(12'h008, 32'h1, 1'b1, 1'b0, 1'b0);
    pin();
    chk("pin_load_n0", 32'(reg2dp_op_load), 32'd0);
    idle(); pin();
    chk("pin_load_n1", 32'(reg2dp_op_load), 32'd0);
    chk("pin_status_0_pend", 32'(status_0), 32'd2);
    idle(); pin();
    chk("pin_load_n2", 32'(reg2dp_op_load), 32'd1);
    chk("pin_status_0_run", 32'(status_0), 32'd1);
    idle(); pin();
    chk("pin_load_n3", 32'(reg2dp_op_load), 32'd0);
    chk("pin_op_en_busy", 32'(reg2dp_op_en), 32'd1);

    drive(12'h010, 32'h55, 1'b1, 1'b1, 1'b0);
    pin();
    chk("pin_d1_wren_g1", 32'(d1_reg_wren), 32'd1);
    drive(12'h008, 32'h1, 1'b1, 1'b1, 1'b0);
    idle(); pin();
    chk("pin_status_1_pend", 32'(status_1), 32'd2);

    drive(12'h010, 32'h5, 1'b1, 1'b0, 1'b0);
    pin();
    chk("pin_d0_locked", 32'(d0_reg_wren), 32'd0);
    idle(); pin();
    chk("pin_err_pulse", 32'(wr_locked_err), 32'd1);
    idle(); pin();
    chk("pin_err_clear", 32'(wr_locked_err), 32'd0);

    drive(12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
    idle();
    idle(); pin();
    chk("pin_status_0_done", 32'(status_0), 32'd0);
    chk("pin_consumer_1", 32'(consumer), 32'd1);
    idle(); pin();
    chk("pin_load_g1", 32'(reg2dp_op_load), 32'd1);
    chk("pin_status_1_run", 32'(status_1), 32'd1);

    idle();
    drive(12'h000, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(12'h008, 32'h1, 1'b1, 1'b1, 1'b0);
    idle(); pin();
    chk("pin_clear_wins_err", 32'(wr_locked_err), 32'd1);
    chk("pin_clear_wins_stat", 32'(status_1), 32'd0);
    chk("pin_consumer_wrap", 32'(consumer), 32'd0);
    idle(); pin();
    chk("pin_no_relaunch", 32'(reg2dp_op_load), 32'd0);

    drive(12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(); pin();
    chk("pin_idle_done_cons", 32'(consumer), 32'd0);
    chk("pin_idle_done_open", 32'(reg2dp_op_en), 32'd0);

    drive(12'h008, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(); idle(); pin();
    chk("pin_wr0_status", 32'(status_0), 32'd0);
    chk("pin_wr0_load", 32'(reg2dp_op_load), 32'd0);

    drive(12'h004, 32'h1, 1'b1, 1'b0, 1'b0);
    pin();
    chk("pin_below_base", 32'(d0_reg_wren), 32'd0);
    drive(12'h0fc, 32'h1, 1'b1, 1'b0, 1'b0);
    pin();
    chk("pin_at_top", 32'(d0_reg_wren), 32'd1);
    drive(12'h100, 32'h1, 1'b1, 1'b0, 1'b0);
    pin();
    chk("pin_above_top", 32'(d0_reg_wren), 32'd0);

    drive(12'h008, 32'h1, 1'b1, 1'b0, 1'b0);
    idle(); idle(); idle(); pin();
    chk("pin_busy_before_rst", 32'(reg2dp_op_en), 32'd1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("pin_rst_op_en", 32'(reg2dp_op_en), 32'd0);
    chk("pin_rst_status_0", 32'(status_0), 32'd0);
    chk("pin_rst_op_load", 32'(reg2dp_op_load), 32'd0);
    chk("pin_rst_consumer", 32'(consumer), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    drive(12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(); idle(); pin();
    chk("pin_late_done_cons", 32'(consumer), 32'd0);
    chk("pin_late_done_stat", 32'(status_0), 32'd0);
    chk("pin_late_done_en", 32'(reg2dp_op_en), 32'd0);

    idle(); idle();
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
